param_lifo_stack: RTL
=====================

Name: param_lifo_stack

Overview:
- Parametrised LIFO stack: configurable data width and depth.
- Richer command set than a plain push/pop stack: peek, replace (pop+push in one cycle), clear.
- Occupancy count, almost-full flag, per-operation and sticky error reporting.
- Fully synchronous to one clock edge; used as a general-purpose return/operand stack in homework datapaths.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2).
- AF_LEVEL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH).

Ports:
- clk  input  1  clock; all state changes at posedge.
- rst  input  1  asynchronous active-high reset.
- data_in  input  WIDTH  write data for PUSH/REPLACE, sampled at posedge.
- cmd  input  3  000 NOP, 001 CLR, 010 PUSH, 011 POP, 100 PEEK, 101 REPLACE, 110/111 reserved.
- data_out  output  WIDTH  read data from POP/PEEK/REPLACE.
- data_valid  output  1  high for one cycle when data_out carries a new read result.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- almost_full  output  1  count>=AF_LEVEL.
- error  output  1  one-cycle pulse after an illegal command.
- err_sticky  output  1  latched error; cleared only by rst or CLR.

Behaviour:
- Reset (async, rst=1): count=0, empty=1, full=0, almost_full=0 (AF_LEVEL>=1), data_out=0, data_valid=0, error=0, err_sticky=0.
  - Storage array is not reset; its contents are unobservable until written.
  - Reset asserted mid-operation aborts that operation; first posedge after release is a normal command cycle.
- Storage: entries 0..DEPTH-1; top of stack is entry count-1. No wrap-around; count saturates by rejection, never by modulo.
- Every output is registered and updated at the posedge that samples cmd, so results are visible 1 cycle after the command. All flags reflect post-operation count.
- data_valid=1 only after a successful POP/PEEK/REPLACE; otherwise 0. data_out holds its last value when data_valid=0.
- NOP: no state change; error=0.
- CLR: count=0, flags recomputed, error=0, err_sticky=0, data_valid=0. Always legal, including when already empty.
- PUSH:
  - if !full: mem[count]=data_in, count+1.
  - if full: no change, error=1.
- POP:
  - if !empty: data_out=mem[count-1], data_valid=1, count-1.
  - if empty: no change, error=1, data_valid=0.
- PEEK:
  - if !empty: data_out=mem[count-1], data_valid=1, count unchanged.
  - if empty: error=1.
- REPLACE:
  - if !empty: data_out=old mem[count-1], data_valid=1, mem[count-1]=data_in, count unchanged. Legal when full.
  - if empty: no change, error=1.
- Reserved cmd (110/111): treated as NOP plus error=1.
- error: asserted exactly one cycle per illegal command. Back-to-back illegal commands keep it high. Any legal command clears it.
- err_sticky: set with error, held until CLR or rst. A CLR in the same cycle wins (cleared).
- The read and write of REPLACE in one cycle must return the pre-write value (read-before-write).

Test Plan:
- rst pulse, then idle -> count=0, empty=1, full=0, error=0, data_valid=0. Assert rst mid-stream after 3 pushes -> count=0 immediately, no clock required.
- DEPTH=8: PUSH 0x11,0x22,...,0x88 -> count 1..8; almost_full rises when count=7; full=1 after 8th push. 9th PUSH 0x99 -> error=1 for one cycle, err_sticky=1, count stays 8.
- From full, 8 POPs -> data_out 0x88,0x77,...,0x11, each with data_valid=1. Then empty=1. 9th POP -> error=1, data_valid=0, count 0.
- PUSH 0xA5, PEEK -> data_out=0xA5, count=1. REPLACE 0x3C -> data_out=0xA5, count=1. POP -> data_out=0x3C, empty=1.
- REPLACE when full (top 0x88, data_in 0xFF) -> data_out=0x88, full stays 1; next POP -> 0xFF.
- cmd=111 -> error=1, state unchanged, err_sticky=1. Then CLR -> count=0, err_sticky=0, error=0.

Source files
------------

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with NOP/CLR/PUSH/POP/PEEK/REPLACE commands, occupancy flags
// and per-command plus sticky error reporting. All outputs are registered.
module param_lifo_stack #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             data_in,
    input  logic [2:0]                   cmd,
    output logic [WIDTH-1:0]             data_out,
    output logic                         data_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         error,
    output logic                         err_sticky
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] CountMax = CW'(DEPTH);
    localparam logic [CW-1:0] AfLevel  = CW'(AF_LEVEL);

    localparam logic [2:0] CmdNop     = 3'b000;
    localparam logic [2:0] CmdClr     = 3'b001;
    localparam logic [2:0] CmdPush    = 3'b010;
    localparam logic [2:0] CmdPop     = 3'b011;
    localparam logic [2:0] CmdPeek    = 3'b100;
    localparam logic [2:0] CmdReplace = 3'b101;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             empty_q, full_q, af_q;
    logic             error_q, error_d;
    logic             sticky_q, sticky_d;

    logic             is_empty, is_full;
    logic [AW-1:0]    top_addr, push_addr;
    logic [WIDTH-1:0] top_data;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == CountMax);
    assign top_addr  = AW'(count_q - 1'b1);
    assign push_addr = AW'(count_q);
    // Combinational read of the pre-write top gives REPLACE its read-before-write result.
    assign top_data  = mem[top_addr];

    always_comb begin
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        error_d      = 1'b0;
        sticky_d     = sticky_q;
        mem_we       = 1'b0;
        mem_waddr    = push_addr;

        case (cmd)
            CmdNop: ;
            CmdClr: begin
                count_d  = '0;
                sticky_d = 1'b0;
            end
            CmdPush: begin
                if (is_full) begin
                    error_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            CmdPop: begin
                if (is_empty) begin
                    error_d = 1'b1;
                end else begin
                    data_out_d   = top_data;
                    data_valid_d = 1'b1;
                    count_d      = count_q - 1'b1;
                end
            end
            CmdPeek: begin
                if (is_empty) begin
                    error_d = 1'b1;
                end else begin
                    data_out_d   = top_data;
                    data_valid_d = 1'b1;
                end
            end
            CmdReplace: begin
                if (is_empty) begin
                    error_d = 1'b1;
                end else begin
                    data_out_d   = top_data;
                    data_valid_d = 1'b1;
                    mem_we       = 1'b1;
                    mem_waddr    = top_addr;
                end
            end
            default: error_d = 1'b1;
        endcase

        if (error_d) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            af_q         <= 1'b0;
            error_q      <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            empty_q      <= (count_d == '0);
            full_q       <= (count_d == CountMax);
            af_q         <= (count_d >= AfLevel);
            error_q      <= error_d;
            sticky_q     <= sticky_d;
        end
    end

    // Storage is intentionally unreset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= data_in;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign error       = error_q;
    assign err_sticky  = sticky_q;

endmodule
